// File: rtl/uart_fifo_ctrl.sv
// Host-mapped UART with programmable divisor and word format, TX/RX FIFOs,
// sticky receive error flags and internal loopback on an 8-bit CS_n/WR_n bus.
module uart_fifo_ctrl_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic         CLK,
  input  logic         RESET_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);
  logic [W-1:0] mem [0:(1<<AW)-1];
  logic [AW:0]  wp, rp;
  logic         do_push, do_pop;

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rp[AW-1:0]];

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rp <= rp + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wp[AW-1:0]] <= wdata;
  end
endmodule

module uart_fifo_ctrl #(
  parameter logic [15:0] DIV_RESET = 16'd5208,
  parameter int          DATA_BITS = 8,
  parameter int          FIFO_AW   = 4
) (
  input  logic       CLK,
  input  logic       RESET_n,
  input  logic       UART_RX,
  output logic       UART_TX,
  input  logic [2:0] ADDRESS,
  input  logic [7:0] DATA_IN,
  output logic [7:0] DATA_OUT,
  input  logic       CS_n,
  input  logic       WR_n,
  output logic       IRQ
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  logic        cs_q, acc, wr, rd;
  logic [7:0]  ctrl;
  logic [15:0] div, eff_div;

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) cs_q <= 1'b1;
    else          cs_q <= CS_n;
  end
  assign acc     = cs_q & ~CS_n;
  assign wr      = acc & ~WR_n;
  assign rd      = acc & WR_n;
  assign eff_div = (div < 16'd4) ? 16'd4 : div;

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      ctrl <= 8'h00;
      div  <= DIV_RESET;
    end else if (wr) begin
      case (ADDRESS)
        3'd3:    ctrl       <= DATA_IN;
        3'd4:    div[7:0]   <= DATA_IN;
        3'd5:    div[15:8]  <= DATA_IN;
        default: ;
      endcase
    end
  end

  // ---------------- transmit ----------------
  state_t                tx_state, tx_nxt;
  logic                  tx_empty, tx_full, tx_load, tx_tick, tx_last_stop, tx_par_en, tx_line;
  logic [DATA_BITS-1:0]  tx_head, tx_sh;
  logic [15:0]           tx_cnt, tx_div;
  logic [3:0]            tx_bit;
  logic [1:0]            tx_par_mode;
  logic                  tx_stop2, tx_stop_n, tx_par;

  uart_fifo_ctrl_fifo #(.W(DATA_BITS), .AW(FIFO_AW)) u_tx_fifo (
    .CLK(CLK), .RESET_n(RESET_n),
    .push(wr && ADDRESS == 3'd2), .pop(tx_load),
    .wdata(DATA_IN[DATA_BITS-1:0]), .rdata(tx_head),
    .empty(tx_empty), .full(tx_full)
  );

  assign tx_tick      = (tx_cnt == tx_div - 16'd1);
  assign tx_par_en    = (tx_par_mode == 2'b01) || (tx_par_mode == 2'b10);
  assign tx_last_stop = tx_tick && (tx_stop_n == tx_stop2);
  // Reloading straight out of STOP keeps back-to-back frames gap-free.
  assign tx_load      = ~tx_empty && (tx_state == S_IDLE || (tx_state == S_STOP && tx_last_stop));

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) tx_state <= S_IDLE;
    else          tx_state <= tx_nxt;
  end

  always_comb begin
    tx_nxt = tx_state;
    case (tx_state)
      S_IDLE:   if (!tx_empty) tx_nxt = S_START;
      S_START:  if (tx_tick) tx_nxt = S_DATA;
      S_DATA:   if (tx_tick && tx_bit == LAST_BIT) tx_nxt = tx_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (tx_tick) tx_nxt = S_STOP;
      S_STOP:   if (tx_last_stop) tx_nxt = tx_empty ? S_IDLE : S_START;
      default:  tx_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tx_line = 1'b1;
    case (tx_state)
      S_START:  tx_line = 1'b0;
      S_DATA:   tx_line = tx_sh[0];
      S_PARITY: tx_line = tx_par;
      default:  tx_line = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      UART_TX     <= 1'b1;
      tx_cnt      <= 16'd0;
      tx_bit      <= 4'd0;
      tx_stop_n   <= 1'b0;
      tx_div      <= DIV_RESET;
      tx_par_mode <= 2'b00;
      tx_stop2    <= 1'b0;
    end else begin
      UART_TX <= tx_line;
      if (tx_load) begin
        tx_cnt      <= 16'd0;
        tx_bit      <= 4'd0;
        tx_stop_n   <= 1'b0;
        tx_div      <= eff_div;
        tx_par_mode <= ctrl[1:0];
        tx_stop2    <= ctrl[2];
      end else if (tx_state != S_IDLE) begin
        if (tx_tick) begin
          tx_cnt <= 16'd0;
          if (tx_state == S_DATA) tx_bit    <= tx_bit + 4'd1;
          if (tx_state == S_STOP) tx_stop_n <= 1'b1;
        end else begin
          tx_cnt <= tx_cnt + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (tx_load) begin
      tx_sh  <= tx_head;
      tx_par <= (^tx_head) ^ (ctrl[1:0] == 2'b10);
    end else if (tx_state == S_DATA && tx_tick) begin
      tx_sh <= tx_sh >> 1;
    end
  end

  // ---------------- receive ----------------
  state_t                rx_state, rx_nxt;
  logic [2:0]            rx_sync;
  logic                  rx_s, rx_armed, rx_tick, rx_mid, rx_par_en, rx_par_s;
  logic [15:0]           rx_cnt, rx_div;
  logic [3:0]            rx_bit;
  logic [1:0]            rx_par_mode;
  logic [DATA_BITS-1:0]  rx_sh, rx_word_p1, rx_head;
  logic                  rx_push_p1, rx_ferr_p1, rx_perr_p1;
  logic                  rx_empty, rx_full;
  logic                  ovr, ferr, perr, st_clr;

  assign rx_s      = rx_sync[2];
  assign rx_tick   = (rx_cnt == rx_div - 16'd1);
  assign rx_mid    = (rx_cnt == (rx_div >> 1));
  assign rx_par_en = (rx_par_mode == 2'b01) || (rx_par_mode == 2'b10);

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) rx_state <= S_IDLE;
    else          rx_state <= rx_nxt;
  end

  always_comb begin
    rx_nxt = rx_state;
    case (rx_state)
      S_IDLE:   if (rx_armed && !rx_s) rx_nxt = S_START;
      S_START:  if (rx_mid) rx_nxt = rx_s ? S_IDLE : S_DATA;
      S_DATA:   if (rx_tick && rx_bit == LAST_BIT) rx_nxt = rx_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (rx_tick) rx_nxt = S_STOP;
      S_STOP:   if (rx_tick) rx_nxt = S_IDLE;
      default:  rx_nxt = S_IDLE;
    endcase
  end

  // Config is re-latched every IDLE cycle, so the value held is the one seen on leaving IDLE.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      rx_sync     <= 3'b111;
      rx_armed    <= 1'b0;
      rx_cnt      <= 16'd0;
      rx_bit      <= 4'd0;
      rx_div      <= DIV_RESET;
      rx_par_mode <= 2'b00;
      rx_push_p1  <= 1'b0;
      rx_ferr_p1  <= 1'b0;
      rx_perr_p1  <= 1'b0;
    end else begin
      rx_sync    <= {rx_sync[1:0], ctrl[3] ? UART_TX : UART_RX};
      rx_push_p1 <= (rx_state == S_STOP) && rx_tick;
      rx_ferr_p1 <= ~rx_s;
      rx_perr_p1 <= rx_par_en && (rx_par_s != ((^rx_sh) ^ (rx_par_mode == 2'b10)));
      case (rx_state)
        S_IDLE: begin
          if (rx_s) rx_armed <= 1'b1;
          rx_cnt      <= 16'd0;
          rx_bit      <= 4'd0;
          rx_div      <= eff_div;
          rx_par_mode <= ctrl[1:0];
        end
        S_START: rx_cnt <= rx_mid ? 16'd0 : rx_cnt + 16'd1;
        default: begin
          if (rx_tick) begin
            rx_cnt <= 16'd0;
            if (rx_state == S_DATA) rx_bit   <= rx_bit + 4'd1;
            if (rx_state == S_STOP) rx_armed <= 1'b0;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (rx_state == S_DATA && rx_tick)   rx_sh    <= {rx_s, rx_sh[DATA_BITS-1:1]};
    if (rx_state == S_PARITY && rx_tick) rx_par_s <= rx_s;
    if (rx_state == S_STOP && rx_tick)   rx_word_p1 <= rx_sh;
  end

  // ---------------- push stage p1 ----------------
  uart_fifo_ctrl_fifo #(.W(DATA_BITS), .AW(FIFO_AW)) u_rx_fifo (
    .CLK(CLK), .RESET_n(RESET_n),
    .push(rx_push_p1), .pop(rd && ADDRESS == 3'd0),
    .wdata(rx_word_p1), .rdata(rx_head),
    .empty(rx_empty), .full(rx_full)
  );

  assign st_clr = rd && ADDRESS == 3'd1;

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      ovr  <= 1'b0;
      ferr <= 1'b0;
      perr <= 1'b0;
    end else begin
      ovr  <= (rx_push_p1 & rx_full)    | (ovr  & ~st_clr);
      ferr <= (rx_push_p1 & rx_ferr_p1) | (ferr & ~st_clr);
      perr <= (rx_push_p1 & rx_perr_p1) | (perr & ~st_clr);
    end
  end

  always_comb begin
    DATA_OUT = 8'h00;
    case (ADDRESS)
      3'd0: if (!rx_empty) DATA_OUT[DATA_BITS-1:0] = rx_head;
      3'd1: DATA_OUT = {1'b0, tx_empty, perr, ferr, ovr, tx_full,
                        (tx_state != S_IDLE) | ~tx_empty, ~rx_empty};
      3'd3: DATA_OUT = ctrl;
      3'd4: DATA_OUT = div[7:0];
      3'd5: DATA_OUT = div[15:8];
      default: DATA_OUT = 8'h00;
    endcase
  end

  assign IRQ = (~rx_empty & ctrl[4]) | (tx_empty & ctrl[5]);
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Directed bench for uart_fifo_ctrl: divisor 16, 8 data bits, 4-deep FIFOs.
module tb_uart_fifo_ctrl;
  logic       CLK = 1'b0;
  logic       RESET_n = 1'b0;
  logic       UART_RX = 1'b1;
  logic       CS_n = 1'b1;
  logic       WR_n = 1'b1;
  logic [2:0] ADDRESS = 3'd0;
  logic [7:0] DATA_IN = 8'h00;
  logic       UART_TX, IRQ;
  logic [7:0] DATA_OUT;
  int         n_pass = 0;
  int         n_total = 0;

  always #5 CLK = ~CLK;

  uart_fifo_ctrl #(.DIV_RESET(16'd5208), .DATA_BITS(8), .FIFO_AW(2)) dut (
    .CLK(CLK), .RESET_n(RESET_n), .UART_RX(UART_RX), .UART_TX(UART_TX),
    .ADDRESS(ADDRESS), .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT),
    .CS_n(CS_n), .WR_n(WR_n), .IRQ(IRQ)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge CLK); ADDRESS = a; DATA_IN = d; WR_n = 1'b0; CS_n = 1'b0;
    @(negedge CLK); @(negedge CLK); CS_n = 1'b1; WR_n = 1'b1;
    @(negedge CLK);
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    @(negedge CLK); ADDRESS = a; WR_n = 1'b1; CS_n = 1'b0;
    #1 d = DATA_OUT;
    @(negedge CLK); @(negedge CLK); CS_n = 1'b1;
    @(negedge CLK);
  endtask

  task automatic peek(input logic [2:0] a, output logic [7:0] d);
    ADDRESS = a;
    #1 d = DATA_OUT;
  endtask

  task automatic wait_tx_low(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge CLK);
      if (UART_TX === 1'b0) seen = 1'b1;
    end
    if (!seen) begin
      n_total++;
      $display("FAIL %s: no start bit within 300 cycles", name);
    end
  endtask

  task automatic wait_status_bit(input int b, input logic v, input int limit, input string name);
    logic [7:0] st;
    bit         seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge CLK);
      peek(3'd1, st);
      if (st[b] === v) seen = 1'b1;
    end
    if (!seen) begin
      n_total++;
      $display("FAIL %s: STATUS[%0d] never became %b, STATUS=%h", name, b, v, st);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    @(negedge CLK); UART_RX = 1'b0;
    repeat (16) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      UART_RX = d[i];
      repeat (16) @(negedge CLK);
    end
    UART_RX = stop;
    repeat (16) @(negedge CLK);
    UART_RX = 1'b1;
    repeat (16) @(negedge CLK);
  endtask

  task automatic test_reset;
    logic [7:0] v;
    RESET_n = 1'b0;
    repeat (3) @(negedge CLK);
    n_total++; if (UART_TX !== 1'b1) $display("FAIL reset_tx_in_reset: got %b want 1", UART_TX); else n_pass++;
    RESET_n = 1'b1;
    bus_read(3'd1, v);
    n_total++; if (v !== 8'h40) $display("FAIL reset_status: got %h want 40", v); else n_pass++;
    n_total++; if (UART_TX !== 1'b1) $display("FAIL reset_tx: got %b want 1", UART_TX); else n_pass++;
    n_total++; if (IRQ !== 1'b0) $display("FAIL reset_irq: got %b want 0", IRQ); else n_pass++;
    bus_read(3'd4, v);
    n_total++; if (v !== 8'h58) $display("FAIL reset_div_lo: got %h want 58", v); else n_pass++;
    bus_read(3'd5, v);
    n_total++; if (v !== 8'h14) $display("FAIL reset_div_hi: got %h want 14", v); else n_pass++;
    bus_write(3'd6, 8'hFF);
    bus_read(3'd6, v);
    n_total++; if (v !== 8'h00) $display("FAIL reg6_read: got %h want 00", v); else n_pass++;
  endtask

  task automatic test_tx_frame;
    logic [7:0] v;
    logic       exp_bits [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    bus_write(3'd4, 8'd16);
    bus_write(3'd5, 8'd0);
    bus_write(3'd3, 8'h00);
    bus_read(3'd4, v);
    n_total++; if (v !== 8'h10) $display("FAIL div_readback: got %h want 10", v); else n_pass++;
    bus_write(3'd2, 8'hA5);
    wait_tx_low("tx_start");
    peek(3'd1, v);
    n_total++; if (v[1] !== 1'b1) $display("FAIL tx_busy_during: got %b want 1", v[1]); else n_pass++;
    repeat (8) @(negedge CLK);
    for (int i = 0; i < 10; i++) begin
      n_total++;
      if (UART_TX !== exp_bits[i]) $display("FAIL tx_bit%0d: got %b want %b", i, UART_TX, exp_bits[i]);
      else n_pass++;
      repeat (16) @(negedge CLK);
    end
    peek(3'd1, v);
    n_total++; if (v !== 8'h40) $display("FAIL tx_done_status: got %h want 40", v); else n_pass++;
  endtask

  task automatic test_loopback_parity;
    logic [7:0] v;
    bus_write(3'd3, 8'h09);
    bus_write(3'd2, 8'h3C);
    wait_status_bit(0, 1'b1, 400, "loop_rx_wait");
    bus_read(3'd0, v);
    n_total++; if (v !== 8'h3C) $display("FAIL loop_rx_data: got %h want 3c", v); else n_pass++;
    bus_read(3'd1, v);
    n_total++; if ((v & 8'h30) !== 8'h00) $display("FAIL loop_parity_err: got %h want 00", v & 8'h30); else n_pass++;
    wait_status_bit(1, 1'b0, 100, "loop_tx_idle");
    repeat (20) @(negedge CLK);
  endtask

  task automatic test_framing_irq;
    logic [7:0] v;
    bus_write(3'd3, 8'h00);
    send_frame(8'h55, 1'b0);
    @(negedge CLK);
    peek(3'd0, v);
    n_total++; if (v !== 8'h55) $display("FAIL frame_rx_peek: got %h want 55", v); else n_pass++;
    bus_read(3'd1, v);
    n_total++; if (v !== 8'h51) $display("FAIL frame_status1: got %h want 51", v); else n_pass++;
    bus_read(3'd1, v);
    n_total++; if (v !== 8'h41) $display("FAIL frame_status2: got %h want 41", v); else n_pass++;
    bus_write(3'd3, 8'h10);
    n_total++; if (IRQ !== 1'b1) $display("FAIL irq_rx_on: got %b want 1", IRQ); else n_pass++;
    bus_read(3'd0, v);
    n_total++; if (v !== 8'h55) $display("FAIL frame_rx_pop: got %h want 55", v); else n_pass++;
    n_total++; if (IRQ !== 1'b0) $display("FAIL irq_rx_off: got %b want 0", IRQ); else n_pass++;
    bus_read(3'd0, v);
    n_total++; if (v !== 8'h00) $display("FAIL rx_empty_read: got %h want 00", v); else n_pass++;
    bus_write(3'd3, 8'h20);
    n_total++; if (IRQ !== 1'b1) $display("FAIL irq_tx_empty: got %b want 1", IRQ); else n_pass++;
    bus_write(3'd3, 8'h00);
  endtask

  task automatic test_overrun;
    logic [7:0] v;
    logic [7:0] bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    bus_write(3'd3, 8'h08);
    for (int i = 0; i < 5; i++) bus_write(3'd2, bytes[i]);
    peek(3'd1, v);
    n_total++; if (v[2] !== 1'b1) $display("FAIL tx_full: got %b want 1", v[2]); else n_pass++;
    wait_status_bit(3, 1'b1, 2000, "overrun_wait");
    wait_status_bit(1, 1'b0, 200, "overrun_tx_idle");
    bus_read(3'd1, v);
    n_total++; if (v !== 8'h49) $display("FAIL overrun_status: got %h want 49", v); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      bus_read(3'd0, v);
      n_total++;
      if (v !== bytes[i]) $display("FAIL overrun_read%0d: got %h want %h", i, v, bytes[i]);
      else n_pass++;
    end
    bus_read(3'd1, v);
    n_total++; if (v !== 8'h40) $display("FAIL overrun_after: got %h want 40", v); else n_pass++;
  endtask

  task automatic test_glitch_and_reset;
    logic [7:0] v;
    bus_write(3'd3, 8'h00);
    @(negedge CLK); UART_RX = 1'b0;
    repeat (5) @(negedge CLK);
    UART_RX = 1'b1;
    repeat (40) @(negedge CLK);
    peek(3'd1, v);
    n_total++; if (v !== 8'h40) $display("FAIL glitch_status: got %h want 40", v); else n_pass++;
    bus_write(3'd2, 8'h5A);
    wait_tx_low("reset_start");
    repeat (4) @(negedge CLK);
    n_total++; if (UART_TX !== 1'b0) $display("FAIL pre_reset_tx: got %b want 0", UART_TX); else n_pass++;
    #3 RESET_n = 1'b0;
    #1;
    n_total++; if (UART_TX !== 1'b1) $display("FAIL reset_mid_tx: got %b want 1", UART_TX); else n_pass++;
    peek(3'd1, v);
    n_total++; if (v !== 8'h40) $display("FAIL reset_mid_status: got %h want 40", v); else n_pass++;
    repeat (2) @(negedge CLK);
    RESET_n = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_loopback_parity();
    test_framing_irq();
    test_overrun();
    test_glitch_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
